control_caida_cubos: RTL and testbench
======================================

Name: control_caida_cubos

Overview:
Game-level scheduler for the falling cubes of the basket game.
- Paces cube releases from the frame tick and drives the one-cycle advance pulse of the one-hot next-cube register.
- Keeps the per-cube "falling" mask that enables drawing.
- Retires cubes on catch or miss events, and tracks score, lives and game-over.
- Sits between the frame-timing logic and the cube-drawing / collision logic.

Parameters:
N_CUBOS, 5, number of cube slots; must equal the width of the next-cube register.
INTERVALO, 50, frame ticks between release attempts; must be at least 2.
VIDAS, 3, lives at game start.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high; clears the block to REPOSO
tick  in  1  one-cycle frame pulse
iniciar  in  1  one-cycle start or restart request
cubos_sel  in  N_CUBOS  current one-hot value of the next-cube register (slot to release next)
atrapado  in  N_CUBOS  per-cube catch events; several bits may be high at once
perdido  in  N_CUBOS  per-cube floor-hit (miss) events
pulso_siguiente  out  1  registered one-cycle advance pulse to the next-cube register
activos  out  N_CUBOS  registered mask of cubes currently falling
puntaje  out  8  registered score, saturates at 255
vidas  out  clog2(VIDAS+1)  registered remaining lives
fin_juego  out  1  registered; high while in FIN

Behaviour:
Reset values:
- pulso_siguiente=0, activos=0, puntaje=0, vidas=VIDAS, fin_juego=0.
- Interval counter=0, pendiente=0, state=REPOSO.
- Reset mid-game overrides every other event in the same cycle.

FSM states:
- REPOSO: only iniciar is acted on. iniciar -> JUGANDO with pendiente=1, counter=0.
- JUGANDO: iniciar is ignored. When vidas reaches 0 -> FIN. activos is cleared in the same edge, and no release is issued in that cycle.
- FIN: fin_juego=1, activos=0, pulso_siguiente=0. iniciar -> JUGANDO with puntaje=0, vidas=VIDAS, counter=0, pendiente=1.

Release pacing (JUGANDO only):
- Counter increments on tick.
- On a tick with counter==INTERVALO-1: counter wraps to 0 and pendiente is set.
- If pendiente is already set, it stays set; release requests do not queue beyond one.

Release rule:
- Condition: pendiente==1 and (activos & cubos_sel)==0.
- On the next edge: activos |= cubos_sel, pendiente cleared, pulso_siguiente=1 for exactly that one cycle.
- Release latency is therefore 1 cycle.
- If the selected slot is still falling, the release stalls (pendiente held) until that slot is retired. Slots are never skipped.

Retire rule:
- Only event bits that have the matching activos bit set are valid. Bits for inactive slots are ignored.
- Valid atrapado: clear the activos bit; puntaje += popcount(valid catches), saturating at 255.
- Valid perdido: clear the activos bit; vidas -= popcount(valid misses), floored at 0.
- atrapado and perdido on the same bit in the same cycle: the catch wins, and no life is lost for that bit.

Simultaneous release and retire:
- Both apply in the same edge, to different bits.
- The release check uses the pre-edge activos. A slot freed in cycle k is releasable in cycle k+1.

Optional Feature:
Macro: CANASTA_ACELERAR_EN.
- Defined: internal interval register starts at INTERVALO. In any cycle where puntaje/8 increases, the interval decreases by 4, floored at 8; it is used as the counter wrap value. Reset and restart reload INTERVALO.
- Undefined: the interval is the constant INTERVALO, and no extra registers are built.

Decomposition:
- Package canasta_pkg holds:
  - the state enum (REPOSO, JUGANDO, FIN);
  - N_CUBOS default;
  - score width 8;
  - the acceleration step of 4 and floor of 8.
- Sub-module contador_intervalo: tick divider with load, wrap value and wrap pulse; reused for the interval counter.
- Popcount stays inline.

Test Plan:
- Bench setting: INTERVALO=4, N_CUBOS=5, VIDAS=3.
- Test 1: reset, then iniciar -> pulso_siguiente one cycle later; activos=00001 with cubos_sel=00001; then the next pulse after 4 ticks.
- Test 2: hold cube 0 active with the register wrapped back to 00001 -> pulso_siguiente stays 0 (stall); assert atrapado=00001 -> release 1 cycle after the clear; puntaje=1.
- Test 3: activos=00011 with perdido=00011 in one cycle -> vidas 3->1, activos=0; one more valid miss -> vidas=0, fin_juego=1 next cycle, no further pulses.
- Test 4: atrapado=perdido=00001 with cube 0 active -> puntaje+1, vidas unchanged; atrapado=00100 with cube 2 inactive -> ignored.
- Test 5: puntaje at 254 with 2 valid catches -> puntaje=255; reset asserted during a release cycle -> all outputs at reset values, pulso_siguiente=0.
- Test 6: with CANASTA_ACELERAR_EN, INTERVALO=16 -> after the 8th catch, the release spacing becomes 12 ticks.

Source files
------------

// File: rtl/canasta_pkg.sv
// -----------------------------------------------------------------------------
// canasta_pkg
// Shared definitions for the falling-cube scheduler of the basket game:
// game state encoding, default slot count, score width and the constants
// that control release acceleration (CANASTA_ACELERAR_EN builds only).
// -----------------------------------------------------------------------------
package canasta_pkg;

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    JUGANDO = 2'd1,
    FIN     = 2'd2
  } estado_t;

  localparam int N_CUBOS_DEF   = 5;
  localparam int ANCHO_PUNTAJE = 8;

  // Each new multiple of 8 points shortens the release interval by PASO_ACEL
  // ticks, never going below PISO_ACEL ticks.
  localparam int PASO_ACEL = 4;
  localparam int PISO_ACEL = 8;

endpackage

// File: rtl/control_caida_cubos_contador_intervalo.sv
// -----------------------------------------------------------------------------
// contador_intervalo
// Tick divider with synchronous load. Counts enabled ticks and wraps after
// i_tope of them, producing a one-cycle wrap pulse on the wrapping tick.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high; clears the count
//   i_cargar    restart the count from zero (priority over i_habilitar)
//   i_habilitar one counted tick
//   i_tope      wrap value (number of ticks per period), must be >= 1
//   o_envuelve  high on the enabled tick that completes a period
// -----------------------------------------------------------------------------
module contador_intervalo #(
  parameter int ANCHO = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_cargar,
  input  logic             i_habilitar,
  input  logic [ANCHO-1:0] i_tope,
  output logic             o_envuelve
);

  localparam logic [ANCHO-1:0] UNO = ANCHO'(1);

  logic [ANCHO-1:0] r_cuenta;
  logic             w_ultimo;

  // ">=" rather than "==" so a wrap value that shrinks below the running
  // count still wraps on the next tick instead of running to overflow.
  assign w_ultimo   = (r_cuenta >= (i_tope - UNO));
  assign o_envuelve = i_habilitar & w_ultimo;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset || i_cargar) begin
      r_cuenta <= '0;
    end else if (i_habilitar) begin
      r_cuenta <= w_ultimo ? '0 : r_cuenta + UNO;
    end
  end

endmodule

// File: rtl/control_caida_cubos.sv
// -----------------------------------------------------------------------------
// control_caida_cubos
// Game-level scheduler for the falling cubes. Paces releases from the frame
// tick, pulses the one-hot next-cube register, keeps the mask of falling
// cubes, retires cubes on catch/miss and tracks score, lives and game over.
//
// Optional feature: define CANASTA_ACELERAR_EN to shorten the release
// interval as the score grows. Without it the interval is the constant
// INTERVALO.
//
// Ports:
//   clk             system clock
//   reset           synchronous, active-high; returns to REPOSO
//   tick            one-cycle frame pulse
//   iniciar         one-cycle start / restart request
//   cubos_sel       one-hot slot that the next release will use
//   atrapado        per-cube catch events
//   perdido         per-cube miss (floor hit) events
//   pulso_siguiente one-cycle advance pulse to the next-cube register
//   activos         mask of cubes currently falling
//   puntaje         score, saturating at 255
//   vidas           remaining lives
//   fin_juego       high while the game is over
// -----------------------------------------------------------------------------
module control_caida_cubos
  import canasta_pkg::*;
#(
  parameter int N_CUBOS   = N_CUBOS_DEF,
  parameter int INTERVALO = 50,
  parameter int VIDAS     = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tick,
  input  logic                       iniciar,
  input  logic [N_CUBOS-1:0]         cubos_sel,
  input  logic [N_CUBOS-1:0]         atrapado,
  input  logic [N_CUBOS-1:0]         perdido,
  output logic                       pulso_siguiente,
  output logic [N_CUBOS-1:0]         activos,
  output logic [ANCHO_PUNTAJE-1:0]   puntaje,
  output logic [$clog2(VIDAS+1)-1:0] vidas,
  output logic                       fin_juego
);

  localparam int ANCHO_INT   = $clog2(INTERVALO + 1);
  localparam int ANCHO_VIDAS = $clog2(VIDAS + 1);
  localparam int ANCHO_CNT   = $clog2(N_CUBOS + 1);

  estado_t                  r_estado, w_estado_sig;
  logic                     r_pendiente, w_pendiente_sig;
  logic                     r_pulso, w_libera;
  logic [N_CUBOS-1:0]       r_activos, w_activos_sig;
  logic [ANCHO_PUNTAJE-1:0] r_puntaje, w_puntaje_sig;
  logic [ANCHO_VIDAS-1:0]   r_vidas, w_vidas_sig;
  logic                     r_fin;
  logic                     w_cargar;
  logic                     w_envuelve;
  logic [ANCHO_INT-1:0]     w_tope;

  // Events count only for cubes that are actually falling; a catch on the
  // same bit as a miss wins, so the miss is masked out.
  logic [N_CUBOS-1:0]       w_atr_v, w_per_v;
  logic [ANCHO_CNT-1:0]     w_n_atr, w_n_per;
  logic [ANCHO_PUNTAJE:0]   w_suma;
  logic [ANCHO_PUNTAJE-1:0] w_puntaje_ret;
  logic [ANCHO_VIDAS-1:0]   w_vidas_ret;

  assign w_atr_v = atrapado & r_activos;
  assign w_per_v = perdido & r_activos & ~atrapado;

  always_comb begin
    w_n_atr = '0;
    w_n_per = '0;
    for (int i = 0; i < N_CUBOS; i++) begin
      w_n_atr = w_n_atr + ANCHO_CNT'(w_atr_v[i]);
      w_n_per = w_n_per + ANCHO_CNT'(w_per_v[i]);
    end
  end

  assign w_suma        = {1'b0, r_puntaje} + (ANCHO_PUNTAJE + 1)'(w_n_atr);
  assign w_puntaje_ret = w_suma[ANCHO_PUNTAJE] ? '1 : w_suma[ANCHO_PUNTAJE-1:0];
  assign w_vidas_ret   = (int'(w_n_per) >= int'(r_vidas)) ? '0
                                                           : r_vidas - ANCHO_VIDAS'(w_n_per);

  contador_intervalo #(
    .ANCHO (ANCHO_INT)
  ) u_contador (
    .clk         (clk),
    .reset       (reset),
    .i_cargar    (w_cargar),
    .i_habilitar (tick && (r_estado == JUGANDO)),
    .i_tope      (w_tope),
    .o_envuelve  (w_envuelve)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_estado_sig    = r_estado;
    w_pendiente_sig = r_pendiente;
    w_activos_sig   = r_activos;
    w_puntaje_sig   = r_puntaje;
    w_vidas_sig     = r_vidas;
    w_libera        = 1'b0;
    w_cargar        = 1'b0;

    case (r_estado)
      REPOSO, FIN: begin
        w_activos_sig = '0;
        if (iniciar) begin
          w_estado_sig    = JUGANDO;
          w_pendiente_sig = 1'b1;
          w_puntaje_sig   = '0;
          w_vidas_sig     = ANCHO_VIDAS'(VIDAS);
          w_cargar        = 1'b1;
        end
      end

      JUGANDO: begin
        w_puntaje_sig = w_puntaje_ret;
        w_vidas_sig   = w_vidas_ret;
        if (w_vidas_ret == '0) begin
          // Losing the last life ends the game on this edge; nothing is
          // released and the mask is dropped.
          w_estado_sig    = FIN;
          w_activos_sig   = '0;
          w_pendiente_sig = 1'b0;
        end else begin
          // The release check sees the pre-edge mask, so a slot freed this
          // cycle becomes releasable one cycle later.
          w_libera        = r_pendiente && ((r_activos & cubos_sel) == '0);
          w_activos_sig   = (r_activos & ~(w_atr_v | w_per_v))
                          | (w_libera ? cubos_sel : '0);
          w_pendiente_sig = (r_pendiente && !w_libera) || w_envuelve;
        end
      end

      default: begin
        w_estado_sig  = REPOSO;
        w_activos_sig = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_estado    <= REPOSO;
      r_pendiente <= 1'b0;
      r_pulso     <= 1'b0;
      r_activos   <= '0;
      r_puntaje   <= '0;
      r_vidas     <= ANCHO_VIDAS'(VIDAS);
      r_fin       <= 1'b0;
    end else begin
      r_estado    <= w_estado_sig;
      r_pendiente <= w_pendiente_sig;
      r_pulso     <= w_libera;
      r_activos   <= w_activos_sig;
      r_puntaje   <= w_puntaje_sig;
      r_vidas     <= w_vidas_sig;
      r_fin       <= (w_estado_sig == FIN);
    end
  end

`ifdef CANASTA_ACELERAR_EN
  logic [ANCHO_INT-1:0] r_intervalo;

  always_ff @(posedge clk) begin
    if (reset || w_cargar) begin
      r_intervalo <= ANCHO_INT'(INTERVALO);
    end else if ((r_estado == JUGANDO) &&
                 (w_puntaje_sig[ANCHO_PUNTAJE-1:3] > r_puntaje[ANCHO_PUNTAJE-1:3])) begin
      if (int'(r_intervalo) >= PISO_ACEL + PASO_ACEL) begin
        r_intervalo <= r_intervalo - ANCHO_INT'(PASO_ACEL);
      end else if (int'(r_intervalo) > PISO_ACEL) begin
        r_intervalo <= ANCHO_INT'(PISO_ACEL);
      end
    end
  end

  assign w_tope = r_intervalo;
`else
  assign w_tope = ANCHO_INT'(INTERVALO);
`endif

  assign pulso_siguiente = r_pulso;
  assign activos         = r_activos;
  assign puntaje         = r_puntaje;
  assign vidas           = r_vidas;
  assign fin_juego       = r_fin;

endmodule

// File: tb/tb_control_caida_cubos.sv
// -----------------------------------------------------------------------------
// tb_control_caida_cubos
// Directed bench for control_caida_cubos with N_CUBOS=5, VIDAS=3. The default
// build runs with INTERVALO=4; with CANASTA_ACELERAR_EN it runs INTERVALO=16
// and exercises the release acceleration. tick is held high, so one cycle is
// one frame tick. The bench models the one-hot next-cube register itself:
// it rotates on the edge that samples pulso_siguiente and reloads on reset.
// -----------------------------------------------------------------------------
module tb_control_caida_cubos;

`ifdef CANASTA_ACELERAR_EN
  localparam int INTERVALO = 16;
`else
  localparam int INTERVALO = 4;
`endif
  localparam int N     = 5;
  localparam int VIDAS = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         tick = 1'b1;
  logic         iniciar = 1'b0;
  logic [N-1:0] sel = 5'b00001;
  logic [N-1:0] atrapado = '0;
  logic [N-1:0] perdido = '0;
  logic         pulso_siguiente;
  logic [N-1:0] activos;
  logic [7:0]   puntaje;
  logic [1:0]   vidas;
  logic         fin_juego;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  control_caida_cubos #(
    .N_CUBOS   (N),
    .INTERVALO (INTERVALO),
    .VIDAS     (VIDAS)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .tick            (tick),
    .iniciar         (iniciar),
    .cubos_sel       (sel),
    .atrapado        (atrapado),
    .perdido         (perdido),
    .pulso_siguiente (pulso_siguiente),
    .activos         (activos),
    .puntaje         (puntaje),
    .vidas           (vidas),
    .fin_juego       (fin_juego)
  );

  // One clock edge; outputs are observed 1 time unit after it.
  task automatic tic();
    logic p, r;
    p = pulso_siguiente;
    r = reset;
    @(posedge clk);
    #1;
    if (r) sel = 5'b00001;
    else if (p) sel = {sel[N-2:0], sel[N-1]};
  endtask

  // Applies atr during the first cycle, then waits for the next pulse.
  // n = cycles from call to the cycle in which the pulse is visible.
  task automatic wait_pulse(input logic [N-1:0] atr, output int n);
    n = 0;
    atrapado = atr;
    do begin
      tic();
      atrapado = '0;
      n++;
    end while (!pulso_siguiente && n < 200);
    n_vec++;
    if (!pulso_siguiente) begin
      n_err++;
      $display("FAIL pulse_timeout: no pulso_siguiente after %0d cycles, required one", n);
    end
  endtask

  task automatic start_game();
    reset = 1'b1; iniciar = 1'b0; atrapado = '0; perdido = '0;
    tic();
    reset = 1'b0; iniciar = 1'b1;
    tic();
    iniciar = 1'b0;
    tic();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tic();
    reset = 1'b0;
    n_vec += 5;
    if (pulso_siguiente !== 1'b0) begin n_err++; $display("FAIL rst_pulso: got %b want 0", pulso_siguiente); end
    if (activos !== 5'b0) begin n_err++; $display("FAIL rst_activos: got %b want 00000", activos); end
    if (puntaje !== 8'd0) begin n_err++; $display("FAIL rst_puntaje: got %0d want 0", puntaje); end
    if (vidas !== 2'd3) begin n_err++; $display("FAIL rst_vidas: got %0d want 3", vidas); end
    if (fin_juego !== 1'b0) begin n_err++; $display("FAIL rst_fin: got %b want 0", fin_juego); end
    // Idle REPOSO with ticks: nothing is released.
    repeat (INTERVALO + 2) tic();
    n_vec++;
    if (pulso_siguiente !== 1'b0 || activos !== 5'b0) begin
      n_err++; $display("FAIL idle_reposo: pulso=%b activos=%b want 0/00000", pulso_siguiente, activos);
    end
  endtask

  task automatic test_release();
    int n;
    iniciar = 1'b1;
    tic();
    iniciar = 1'b0;
    n_vec++;
    if (pulso_siguiente !== 1'b0) begin n_err++; $display("FAIL start_edge_pulso: got %b want 0", pulso_siguiente); end
    tic();
    n_vec += 2;
    if (pulso_siguiente !== 1'b1) begin n_err++; $display("FAIL first_pulso: got %b want 1", pulso_siguiente); end
    if (activos !== 5'b00001) begin n_err++; $display("FAIL first_activos: got %b want 00001", activos); end
    wait_pulse('0, n);
    n_vec += 2;
    if (n != 4) begin n_err++; $display("FAIL spacing_1: got %0d want 4", n); end
    if (activos !== 5'b00011) begin n_err++; $display("FAIL activos_2: got %b want 00011", activos); end
  endtask

  task automatic test_stall();
    int n, cnt;
    for (int i = 0; i < 3; i++) begin
      wait_pulse('0, n);
      n_vec++;
      if (n != 4) begin n_err++; $display("FAIL spacing_fill%0d: got %0d want 4", i, n); end
    end
    n_vec++;
    if (activos !== 5'b11111) begin n_err++; $display("FAIL activos_full: got %b want 11111", activos); end
    cnt = 0;
    repeat (8) begin
      tic();
      if (pulso_siguiente) cnt++;
    end
    n_vec++;
    if (cnt != 0) begin n_err++; $display("FAIL stall_pulses: got %0d want 0", cnt); end
    atrapado = 5'b00001;
    tic();
    atrapado = '0;
    n_vec += 3;
    if (pulso_siguiente !== 1'b0) begin n_err++; $display("FAIL clear_edge_pulso: got %b want 0", pulso_siguiente); end
    if (puntaje !== 8'd1) begin n_err++; $display("FAIL catch_score: got %0d want 1", puntaje); end
    if (activos !== 5'b11110) begin n_err++; $display("FAIL catch_activos: got %b want 11110", activos); end
    tic();
    n_vec += 2;
    if (pulso_siguiente !== 1'b1) begin n_err++; $display("FAIL unstall_pulso: got %b want 1", pulso_siguiente); end
    if (activos !== 5'b11111) begin n_err++; $display("FAIL unstall_activos: got %b want 11111", activos); end
  endtask

  task automatic test_miss();
    int n, cnt;
    start_game();
    wait_pulse('0, n);
    n_vec++;
    if (activos !== 5'b00011) begin n_err++; $display("FAIL miss_setup: got %b want 00011", activos); end
    perdido = 5'b00011;
    tic();
    perdido = '0;
    n_vec += 3;
    if (vidas !== 2'd1) begin n_err++; $display("FAIL double_miss_vidas: got %0d want 1", vidas); end
    if (activos !== 5'b0) begin n_err++; $display("FAIL double_miss_activos: got %b want 00000", activos); end
    if (fin_juego !== 1'b0) begin n_err++; $display("FAIL double_miss_fin: got %b want 0", fin_juego); end
    wait_pulse('0, n);
    n_vec++;
    if (activos !== 5'b00100) begin n_err++; $display("FAIL third_release: got %b want 00100", activos); end
    perdido = 5'b00100;
    tic();
    perdido = '0;
    n_vec += 3;
    if (vidas !== 2'd0) begin n_err++; $display("FAIL last_miss_vidas: got %0d want 0", vidas); end
    if (fin_juego !== 1'b1) begin n_err++; $display("FAIL last_miss_fin: got %b want 1", fin_juego); end
    if (activos !== 5'b0) begin n_err++; $display("FAIL last_miss_activos: got %b want 00000", activos); end
    cnt = 0;
    repeat (3 * INTERVALO) begin
      tic();
      if (pulso_siguiente) cnt++;
    end
    n_vec += 2;
    if (cnt != 0) begin n_err++; $display("FAIL fin_pulses: got %0d want 0", cnt); end
    if (fin_juego !== 1'b1) begin n_err++; $display("FAIL fin_hold: got %b want 1", fin_juego); end
    // Restart from FIN.
    iniciar = 1'b1;
    tic();
    iniciar = 1'b0;
    n_vec += 3;
    if (fin_juego !== 1'b0) begin n_err++; $display("FAIL restart_fin: got %b want 0", fin_juego); end
    if (vidas !== 2'd3) begin n_err++; $display("FAIL restart_vidas: got %0d want 3", vidas); end
    if (puntaje !== 8'd0) begin n_err++; $display("FAIL restart_puntaje: got %0d want 0", puntaje); end
  endtask

  task automatic test_catch_priority();
    start_game();
    n_vec++;
    if (activos !== 5'b00001) begin n_err++; $display("FAIL prio_setup: got %b want 00001", activos); end
    atrapado = 5'b00001; perdido = 5'b00001;
    tic();
    atrapado = '0; perdido = '0;
    n_vec += 3;
    if (puntaje !== 8'd1) begin n_err++; $display("FAIL prio_score: got %0d want 1", puntaje); end
    if (vidas !== 2'd3) begin n_err++; $display("FAIL prio_vidas: got %0d want 3", vidas); end
    if (activos !== 5'b0) begin n_err++; $display("FAIL prio_activos: got %b want 00000", activos); end
    atrapado = 5'b00100; perdido = 5'b00010;
    tic();
    atrapado = '0; perdido = '0;
    n_vec += 2;
    if (puntaje !== 8'd1) begin n_err++; $display("FAIL inactive_score: got %0d want 1", puntaje); end
    if (vidas !== 2'd3) begin n_err++; $display("FAIL inactive_vidas: got %0d want 3", vidas); end
  endtask

  task automatic test_saturation_reset();
    int n;
    logic [N-1:0] rel, prev;
    start_game();
    rel = sel;
    for (int i = 0; i < 254; i++) begin
      wait_pulse(rel, n);
      rel = sel;
    end
    n_vec++;
    if (puntaje !== 8'd254) begin n_err++; $display("FAIL score_254: got %0d want 254", puntaje); end
    prev = rel;
    wait_pulse('0, n);
    rel = sel;
    n_vec++;
    if (activos !== (prev | rel)) begin n_err++; $display("FAIL two_active: got %b want %b", activos, prev | rel); end
    atrapado = prev | rel;
    tic();
    atrapado = '0;
    n_vec += 2;
    if (puntaje !== 8'd255) begin n_err++; $display("FAIL score_sat: got %0d want 255", puntaje); end
    if (activos !== 5'b0) begin n_err++; $display("FAIL sat_activos: got %b want 00000", activos); end
    // Next release lands INTERVALO edges after the last pulse; reset there.
    repeat (INTERVALO - 2) tic();
    reset = 1'b1;
    tic();
    reset = 1'b0;
    n_vec += 5;
    if (pulso_siguiente !== 1'b0) begin n_err++; $display("FAIL midreset_pulso: got %b want 0", pulso_siguiente); end
    if (activos !== 5'b0) begin n_err++; $display("FAIL midreset_activos: got %b want 00000", activos); end
    if (puntaje !== 8'd0) begin n_err++; $display("FAIL midreset_puntaje: got %0d want 0", puntaje); end
    if (vidas !== 2'd3) begin n_err++; $display("FAIL midreset_vidas: got %0d want 3", vidas); end
    if (fin_juego !== 1'b0) begin n_err++; $display("FAIL midreset_fin: got %b want 0", fin_juego); end
  endtask

  task automatic test_acelerar();
    int n;
    int sp [10];
    logic [N-1:0] rel;
    start_game();
    rel = sel;
    for (int i = 0; i < 10; i++) begin
      wait_pulse(rel, n);
      sp[i] = n;
      rel = sel;
    end
    n_vec += 4;
    if (sp[6] != 16) begin n_err++; $display("FAIL accel_before: got %0d want 16", sp[6]); end
    if (sp[7] != 12) begin n_err++; $display("FAIL accel_after8: got %0d want 12", sp[7]); end
    if (sp[8] != 12) begin n_err++; $display("FAIL accel_steady: got %0d want 12", sp[8]); end
    if (puntaje !== 8'd10) begin n_err++; $display("FAIL accel_score: got %0d want 10", puntaje); end
  endtask

  initial begin
    test_reset();
`ifdef CANASTA_ACELERAR_EN
    test_acelerar();
`else
    test_release();
    test_stall();
    test_miss();
    test_catch_priority();
    test_saturation_reset();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
